// File: rtl/clockworks_pkg.sv
// Shared constants, types and helpers for the clockworks clock/reset conditioner.
package clockworks_pkg;

    localparam int DIVW_DEFAULT = 16;
    localparam int NCH_MAX      = 16;

    typedef logic [DIVW_DEFAULT-1:0] div_t;

    // Width of a channel-select field; a single channel still needs one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clockworks_tick_chan.sv
// One programmable tick channel: a divisor register plus a wrapping counter
// that emits a registered single-cycle enable every max(div,1) cycles.
module clockworks_tick_chan
    import clockworks_pkg::*;
#(
    parameter int              DIVW     = DIVW_DEFAULT,
    parameter logic [DIVW-1:0] DIV_INIT = DIVW'(2)
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            clr,
    input  logic            run,
    input  logic            load,
    input  logic [DIVW-1:0] load_value,
    output logic            tick,
    output logic [DIVW-1:0] div
);

    logic [DIVW-1:0] cnt;
    logic [DIVW-1:0] last;

    // Terminal count is div-1, with div=0 treated like div=1 (tick every cycle).
    always_comb begin
        last = (div == '0) ? '0 : div - DIVW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            div <= DIV_INIT;
        end else if (load) begin
            div <= load_value;
        end
    end

    always_ff @(posedge CLK) begin
        if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (run) begin
            if (cnt == last) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + DIVW'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/clockworks_multi.sv
// Board clock/reset conditioner: optional slowed design clock, stretched
// active-low design reset and NCH programmable clock-enable tick channels.
module clockworks_multi
    import clockworks_pkg::*;
#(
    parameter  int SLOW         = 0,
    parameter  int RESET_CYCLES = 16,
    parameter  int NCH          = 4,
    parameter  int DIVW         = DIVW_DEFAULT,
    parameter  int DIV_INIT     = 2,
    localparam int SELW         = sel_width(NCH)
) (
    input  logic            CLK,
    input  logic            RESET,
    output logic            clk,
    output logic            resetn,
    input  logic            div_load,
    input  logic [SELW-1:0] div_sel,
    input  logic [DIVW-1:0] div_value,
    input  logic            sync,
    output logic [NCH-1:0]  tick
);

    localparam int RCW = (RESET_CYCLES > 0) ? $clog2(RESET_CYCLES + 1) : 1;

    if (SLOW > 0) begin : g_slow
        logic [SLOW:0] slow_cnt;

        always_ff @(posedge CLK) begin
            if (RESET) begin
                slow_cnt <= '0;
            end else begin
                slow_cnt <= slow_cnt + (SLOW+1)'(1);
            end
        end

        assign clk = slow_cnt[SLOW];
    end else begin : g_pass
        assign clk = CLK;
    end

    logic [RCW-1:0] rst_cnt;

    // resetn rises on the edge that finds the counter already saturated.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rst_cnt <= '0;
            resetn  <= 1'b0;
        end else if (rst_cnt == RCW'(RESET_CYCLES)) begin
            resetn  <= 1'b1;
        end else begin
            rst_cnt <= rst_cnt + RCW'(1);
        end
    end

    // Widen by one bit so the bound compare stays meaningful when NCH == 2^SELW.
    logic sel_ok;
    assign sel_ok = ({1'b0, div_sel} < (SELW+1)'(NCH));

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic load_this;
        assign load_this = div_load & sel_ok & (div_sel == SELW'(i));

        clockworks_tick_chan #(
            .DIVW     (DIVW),
            .DIV_INIT (DIVW'(DIV_INIT))
        ) u_chan (
            .CLK        (CLK),
            .RESET      (RESET),
            .clr        (RESET | ~resetn | sync | load_this),
            .run        (resetn),
            .load       (load_this),
            .load_value (div_value),
            .tick       (tick[i]),
            .div        ()
        );
    end

endmodule

// File: tb/tb_clockworks_multi.sv
// Self-checking bench: two clockworks_multi configurations share stimulus and
// are compared each cycle against an age/modulo reference model.
module tb_clockworks_multi;
    import clockworks_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       div_load;
    logic [1:0] div_sel;
    div_t       div_value;
    logic       sync;

    wire       clk_a, clk_b, resetn_a, resetn_b;
    wire [3:0] tick_a;
    wire [2:0] tick_b;

    clockworks_multi #(.SLOW(0), .RESET_CYCLES(16), .NCH(4), .DIVW(16), .DIV_INIT(2)) u_a (
        .CLK(CLK), .RESET(RESET), .clk(clk_a), .resetn(resetn_a), .div_load(div_load),
        .div_sel(div_sel), .div_value(div_value), .sync(sync), .tick(tick_a)
    );

    clockworks_multi #(.SLOW(3), .RESET_CYCLES(5), .NCH(3), .DIVW(16), .DIV_INIT(3)) u_b (
        .CLK(CLK), .RESET(RESET), .clk(clk_b), .resetn(resetn_b), .div_load(div_load),
        .div_sel(div_sel), .div_value(div_value), .sync(sync), .tick(tick_b)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: per channel, the number of running edges since the last
    // clear ("age"); a tick is due whenever age is a positive multiple of P.
    int m_div [2][4];
    int m_age [2][4];
    bit m_tick[2][4];
    int m_n0  [2];
    bit m_rn  [2];
    int m_sc  = 0;

    function automatic int rc_of(input int k);   return (k == 0) ? 16 : 5; endfunction
    function automatic int nch_of(input int k);  return (k == 0) ? 4 : 3;  endfunction
    function automatic int init_of(input int k); return (k == 0) ? 2 : 3;  endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (RESET) begin
                m_n0[k] = 0;
                m_rn[k] = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    m_div[k][c]  = init_of(k);
                    m_age[k][c]  = 0;
                    m_tick[k][c] = 1'b0;
                end
            end else begin
                bit rn_prev = m_rn[k];
                bit ld      = div_load && (int'(div_sel) < nch_of(k));
                if (m_n0[k] <= rc_of(k)) m_n0[k]++;
                if (ld) m_div[k][div_sel] = int'(div_value);
                for (int c = 0; c < nch_of(k); c++) begin
                    if (!rn_prev || sync || (ld && int'(div_sel) == c)) begin
                        m_age[k][c]  = 0;
                        m_tick[k][c] = 1'b0;
                    end else begin
                        int p = (m_div[k][c] < 1) ? 1 : m_div[k][c];
                        m_age[k][c]++;
                        m_tick[k][c] = (m_age[k][c] % p) == 0;
                    end
                end
                m_rn[k] = (m_n0[k] > rc_of(k));
            end
        end
        m_sc = RESET ? 0 : (m_sc + 1) % 16;
    endtask

    wire [10:0] obs = {clk_a, resetn_a, resetn_b, clk_b, tick_a, tick_b};

    function automatic logic [10:0] exp_vec();
        logic [3:0] ta;
        logic [2:0] tb;
        for (int c = 0; c < 4; c++) ta[c] = m_tick[0][c];
        for (int c = 0; c < 3; c++) tb[c] = m_tick[1][c];
        return {1'b1, m_rn[0], m_rn[1], (m_sc >= 8), ta, tb};
    endfunction

    // Advance one CLK edge and leave the bench 1 time unit after it.
    task automatic cycle();
        @(posedge CLK);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; div_load = 1'b1; div_sel = 2'd0; div_value = 16'd7; sync = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL reset_model cycle=%0d got=%b want=%b", cyc, obs, exp_vec());
            end
            total++;
            if (resetn_a !== 1'b0 || tick_a !== 4'b0 || tick_b !== 3'b0 || clk_b !== 1'b0) begin
                bad++; $display("FAIL reset_values cycle=%0d got=%b", cyc, obs);
            end
        end
        RESET = 1'b0; div_load = 1'b0; sync = 1'b0;
    endtask

    task automatic test_startup();
        int rise_a = -1, rise_clk = -1, first_t0 = -1;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL startup cycle=%0d got=%b want=%b", cyc, obs, exp_vec());
            end
            if (rise_a < 0 && resetn_a === 1'b1) rise_a = k;
            if (rise_clk < 0 && clk_b === 1'b1) rise_clk = k;
            if (first_t0 < 0 && tick_a[0] === 1'b1) first_t0 = k;
        end
        total++;
        if (rise_a !== 17) begin bad++; $display("FAIL resetn_rise got=%0d want=17", rise_a); end
        total++;
        if (rise_clk !== 8) begin bad++; $display("FAIL slow_clk_rise got=%0d want=8", rise_clk); end
        total++;
        if (first_t0 !== 19) begin bad++; $display("FAIL first_tick0 got=%0d want=19", first_t0); end
    endtask

    task automatic test_load();
        div_load = 1'b1; div_sel = 2'd1; div_value = 16'd5;
        cycle();
        div_load = 1'b0;
        total++;
        if (tick_a[1] !== 1'b0) begin bad++; $display("FAIL load_edge_tick got=%b want=0", tick_a[1]); end
        for (int k = 1; k <= 15; k++) begin
            cycle();
            total++;
            if (tick_a[1] !== ((k % 5) == 0)) begin
                bad++; $display("FAIL load_cadence k=%0d got=%b want=%b", k, tick_a[1], (k % 5) == 0);
            end
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL load_model cycle=%0d got=%b want=%b", cyc, obs, exp_vec());
            end
        end
    endtask

    task automatic test_zero_and_ignored();
        div_load = 1'b1; div_sel = 2'd2; div_value = 16'd0;
        cycle();
        div_load = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            total++;
            if (tick_a[2] !== 1'b1) begin bad++; $display("FAIL div_zero k=%0d got=%b want=1", k, tick_a[2]); end
        end
        // Channel 3 exists on the 4-channel unit only; the 3-channel unit must ignore it.
        div_load = 1'b1; div_sel = 2'd3; div_value = 16'd9;
        for (int k = 0; k < 10; k++) begin
            cycle();
            div_load = 1'b0;
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL sel_ignored cycle=%0d got=%b want=%b", cyc, obs, exp_vec());
            end
        end
    endtask

    task automatic test_sync();
        div_load = 1'b1; div_sel = 2'd0; div_value = 16'd3;
        cycle();
        div_load = 1'b0;
        cycle(); cycle();
        div_load = 1'b1; div_sel = 2'd3; div_value = 16'd3;
        cycle();
        div_load = 1'b0;
        cycle();
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        total++;
        if (tick_a !== 4'b0 || tick_b !== 3'b0) begin
            bad++; $display("FAIL sync_edge got=%b/%b want=0/0", tick_a, tick_b);
        end
        for (int k = 1; k <= 9; k++) begin
            cycle();
            total++;
            if ({tick_a[3], tick_a[0]} !== (((k % 3) == 0) ? 2'b11 : 2'b00)) begin
                bad++; $display("FAIL sync_phase k=%0d got=%b%b", k, tick_a[3], tick_a[0]);
            end
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL sync_model cycle=%0d got=%b want=%b", cyc, obs, exp_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        sync = 1'b1; div_load = 1'b1; div_sel = 2'd2; div_value = 16'd4;
        cycle();
        sync = 1'b0; div_sel = 2'd1; div_value = 16'd2;
        cycle();
        div_value = 16'd3;
        cycle();
        div_load = 1'b0;
        for (int k = 0; k < 14; k++) begin
            cycle();
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL back_to_back cycle=%0d got=%b want=%b", cyc, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            div_load  = ($urandom_range(0, 7) == 0);
            div_sel   = 2'($urandom_range(0, 3));
            div_value = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(10, 40))
                                                    : 16'($urandom_range(0, 9));
            sync      = ($urandom_range(0, 19) == 0);
            cycle();
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL random cycle=%0d got=%b want=%b", cyc, obs, exp_vec());
            end
        end
        div_load = 1'b0; sync = 1'b0;
    endtask

    task automatic test_midrun_reset();
        int rise = -1;
        RESET = 1'b1;
        cycle();
        RESET = 1'b0;
        total++;
        if (resetn_a !== 1'b0 || tick_a !== 4'b0 || tick_b !== 3'b0) begin
            bad++; $display("FAIL midrun_reset got=%b", obs);
        end
        // Loaded while resetn is still low: the divisor must survive the stretch.
        div_load = 1'b1; div_sel = 2'd1; div_value = 16'd4;
        for (int k = 1; k <= 40 && rise < 0; k++) begin
            cycle();
            div_load = 1'b0;
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL stretch cycle=%0d got=%b want=%b", cyc, obs, exp_vec());
            end
            if (resetn_a === 1'b1) rise = k;
        end
        total++;
        if (rise !== 17) begin bad++; $display("FAIL midrun_resetn_rise got=%0d want=17", rise); end
        for (int k = 1; k <= 12; k++) begin
            cycle();
            total++;
            if ({tick_a[1], tick_a[0]} !== {((k % 4) == 0), ((k % 2) == 0)}) begin
                bad++; $display("FAIL retained_div k=%0d got=%b%b", k, tick_a[1], tick_a[0]);
            end
            total++;
            if (obs !== exp_vec()) begin
                bad++; $display("FAIL recover cycle=%0d got=%b want=%b", cyc, obs, exp_vec());
            end
        end
    endtask

    initial begin
        RESET = 1'b1; div_load = 1'b0; div_sel = 2'd0; div_value = '0; sync = 1'b0;
        test_reset();
        test_startup();
        test_load();
        test_zero_and_ignored();
        test_sync();
        test_back_to_back();
        test_random();
        test_midrun_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
